// File: rtl/attn_result_streamer_if.sv
// Narrow result stream bundle for attn_result_streamer: capture inputs plus
// the valid/ready word stream and status flags.
interface attn_result_streamer_if #(
  parameter int DATA_W  = 16,
  parameter int N_WORDS = 32,
  parameter int IDX_W   = 5
) ();
  logic                      en;
  logic                      all_done;
  logic [N_WORDS*DATA_W-1:0] final_res;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic [IDX_W-1:0]          out_idx;
  logic                      busy;
  logic                      overrun;

  modport slave (
    input  en, all_done, final_res, out_ready,
    output out_data, out_valid, out_last, out_idx, busy, overrun
  );

  modport master (
    output en, all_done, final_res, out_ready,
    input  out_data, out_valid, out_last, out_idx, busy, overrun
  );
endinterface

// File: rtl/attn_result_streamer.sv
// Captures the wide attention result on the rising edge of all_done and
// streams it out as N_WORDS sequential words over valid/ready.
//
// state    | meaning
// S_IDLE   | no stream in progress, waiting for a start
// S_STREAM | emitting r_cap[r_idx], waiting for each transfer
module attn_result_streamer #(
  parameter int DATA_W  = 16,
  parameter int N_WORDS = 32,
  parameter int IDX_W   = 5
) (
  input logic                  clk,
  input logic                  rst,
  attn_result_streamer_if.slave bus
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t            r_state, w_nxt_state;
  logic [DATA_W-1:0] r_cap [N_WORDS];
  logic [IDX_W-1:0]  r_idx, w_nxt_idx;
  logic              r_done_q;
  logic              r_overrun;
  logic              w_start, w_xfer, w_last_xfer, w_load, w_set_ovr;

  assign w_start     = bus.en & bus.all_done & ~r_done_q;
  assign w_xfer      = (r_state == S_STREAM) & bus.out_ready;
  assign w_last_xfer = w_xfer & (r_idx == IDX_W'(N_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_done_q  <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < N_WORDS; i++) r_cap[i] <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_idx    <= w_nxt_idx;
      r_done_q <= bus.all_done;
      if (w_set_ovr) r_overrun <= 1'b1;
      if (w_load) begin
        for (int i = 0; i < N_WORDS; i++) r_cap[i] <= bus.final_res[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_load      = 1'b0;
    w_set_ovr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_nxt_state = S_STREAM;
          w_nxt_idx   = '0;
          w_load      = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_last_xfer) begin
          // A start landing on the final transfer chains straight into a new stream
          w_nxt_idx = '0;
          if (w_start) begin
            w_load = 1'b1;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end else begin
          if (w_xfer) w_nxt_idx = r_idx + IDX_W'(1);
          if (w_start) w_set_ovr = 1'b1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (r_state == S_STREAM);
    bus.busy      = (r_state == S_STREAM);
    bus.out_idx   = r_idx;
    bus.out_last  = (r_state == S_STREAM) & (r_idx == IDX_W'(N_WORDS - 1));
    bus.out_data  = (r_state == S_STREAM) ? r_cap[r_idx] : '0;
    bus.overrun   = r_overrun;
  end

endmodule

// File: tb/tb_attn_result_streamer.sv
// Self-checking bench for attn_result_streamer: a queue-based model of the
// pending words is compared against every DUT output after each clock edge.
module tb_attn_result_streamer;
  localparam int DATA_W  = 16;
  localparam int N_WORDS = 32;
  localparam int IDX_W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  attn_result_streamer_if #(.DATA_W(DATA_W), .N_WORDS(N_WORDS), .IDX_W(IDX_W)) bus ();

  attn_result_streamer #(.DATA_W(DATA_W), .N_WORDS(N_WORDS), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: words still to be delivered, head is the word currently offered
  logic [DATA_W-1:0] m_q [$];
  bit                m_ovr;
  bit                m_done_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = m_q.size();
    chk("out_valid", 32'(bus.out_valid), 32'(sz > 0));
    chk("busy",      32'(bus.busy),      32'(sz > 0));
    chk("out_data",  32'(bus.out_data),  (sz > 0) ? 32'(m_q[0]) : 32'h0);
    chk("out_idx",   32'(bus.out_idx),   (sz > 0) ? 32'(N_WORDS - sz) : 32'h0);
    chk("out_last",  32'(bus.out_last),  32'(sz == 1));
    chk("overrun",   32'(bus.overrun),   32'(m_ovr));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovr    = 1'b0;
    m_done_q = 1'b0;
  endtask

  // Predict the effect of the coming edge from current inputs, clock, then check
  task automatic tick();
    bit start;
    start = bus.en && bus.all_done && !m_done_q;
    if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
    if (start) begin
      if (m_q.size() == 0) begin
        for (int i = 0; i < N_WORDS; i++) m_q.push_back(bus.final_res[i*DATA_W +: DATA_W]);
      end else begin
        m_ovr = 1'b1;
      end
    end
    m_done_q = bus.all_done;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_random_res();
    for (int i = 0; i < N_WORDS; i++) bus.final_res[i*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  task automatic pulse_done();
    bus.all_done = 1'b1;
    tick();
    bus.all_done = 1'b0;
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.all_done  = 1'b0;
    bus.out_ready = 1'b0;
    bus.final_res = '0;
    model_reset();

    // Reset values
    #1 rst = 1'b1;
    #1 check_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();

    // Basic drain: words 0x1000+i, consumer always ready
    for (int i = 0; i < N_WORDS; i++) bus.final_res[i*DATA_W +: DATA_W] = DATA_W'(16'h1000 + i);
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;
    pulse_done();
    for (int k = 0; k < 36; k++) tick();

    // Backpressure pattern 1,0,0 repeating
    set_random_res();
    bus.out_ready = 1'b1;
    pulse_done();
    for (int k = 0; k < 110; k++) begin
      bus.out_ready = ((k % 3) == 0);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();

    // Held done with the bus overwritten after capture: one stream only
    set_random_res();
    bus.all_done = 1'b1;
    tick();
    bus.final_res = {N_WORDS{16'hFFFF}};
    for (int k = 0; k < 100; k++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.all_done  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) tick();

    // Enable gating: lost start, then a normal one
    set_random_res();
    bus.en = 1'b0;
    pulse_done();
    for (int k = 0; k < 3; k++) tick();
    bus.en = 1'b1;
    pulse_done();
    for (int k = 0; k < 36; k++) tick();

    // Back-to-back: new start coincident with the last transfer
    set_random_res();
    pulse_done();
    for (int k = 0; k < 100 && m_q.size() != 1; k++) tick();
    chk("b2b_reached_last", 32'(bus.out_last), 32'h1);
    set_random_res();
    pulse_done();
    tick();

    // Overrun: second rising edge while word 10 is on the bus
    for (int k = 0; k < 100 && m_q.size() != N_WORDS - 10; k++) tick();
    chk("ovr_at_word10", 32'(bus.out_idx), 32'd10);
    set_random_res();
    pulse_done();
    for (int k = 0; k < 30; k++) tick();

    // Reset mid-stream at index 17
    set_random_res();
    pulse_done();
    for (int k = 0; k < 100 && m_q.size() != N_WORDS - 17; k++) tick();
    chk("rst_at_idx17", 32'(bus.out_idx), 32'd17);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    set_random_res();
    pulse_done();
    for (int k = 0; k < 36; k++) tick();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bus.en        = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) bus.all_done = ~bus.all_done;
      if ($urandom_range(0, 7) == 0) set_random_res();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/attn_result_streamer.md
Name: attn_result_streamer

Overview:
Drains the 512-bit attention result bus produced by pe_8x8_top and emits it as 32 sequential 16-bit words on a valid/ready stream. It captures final_res on the rising edge of all_done and holds a private copy, so the array may be restarted while the stream is still draining. It sits between the attention top and any narrow consumer: a result FIFO, a memory writer, or a checker.

Parameters:
DATA_W, 16, width of one result word.
N_WORDS, 32, number of words in final_res.
IDX_W, 5, width of the word index (clog2 of N_WORDS).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
en  input  1  capture enable; a result is accepted only when en=1.
all_done  input  1  done flag from the attention top; level signal, may stay high for many cycles.
final_res  input  N_WORDS*DATA_W  result bus; word i = final_res[i*DATA_W +: DATA_W].
out_data  output  DATA_W  current word.
out_valid  output  1  out_data holds a valid word.
out_ready  input  1  consumer accepts the word.
out_last  output  1  high with word N_WORDS-1.
out_idx  output  IDX_W  index of the current word.
busy  output  1  a stream is in progress (state STREAM).
overrun  output  1  sticky flag: a result arrived while busy and was dropped.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0, overrun=0; done_q=0; capture register cleared.
- Edge detect: done_q <= all_done every cycle. Define start = en & all_done & ~done_q.
  - A held-high all_done produces exactly one start.
  - A start with en=0 is lost; it is not deferred.
- State IDLE:
  - On start, copy final_res into the capture register, set out_idx=0, out_valid=1 and out_data=word 0, and go to STREAM.
  - Latency: all_done rising at edge N gives out_valid=1 after edge N+1 (capture and output occur at the same edge).
- State STREAM:
  - A transfer is out_valid & out_ready.
  - On a transfer with out_idx<N_WORDS-1: out_idx+1, out_data=next word from the capture register.
  - Without a transfer: all outputs hold. out_valid never drops before its transfer.
  - out_last = (out_idx==N_WORDS-1) & out_valid.
  - On the transfer of the last word: out_valid=0, out_idx=0, go to IDLE.
  - busy=1 throughout STREAM.
- Back-to-back: a transfer of the last word in the same cycle as start recaptures, emits word 0 on the next cycle with no bubble, and stays in STREAM. overrun is not set.
- Overrun: a start in STREAM that is not coincident with the last transfer sets overrun=1 and is ignored. The capture register and the current stream are unaffected. overrun clears only on rst.
- en=0 during STREAM has no effect; the stream completes.
- Reset mid-stream: outputs return to reset values immediately (asynchronously). The remaining words are discarded and there is no partial last.
- Throughput: with out_ready tied high, one word per cycle; 32 words occupy 32 consecutive cycles.
- The capture register is the only wide storage: N_WORDS*DATA_W flops. The output mux is indexed by out_idx.

Test Plan:
- Basic drain: set final_res word i = 16'h1000+i, pulse all_done for 1 cycle with en=1 and out_ready=1 -> words 1000..101F on 32 consecutive cycles, starting the cycle after the capture edge; out_last only with 101F; busy falls after it.
- Backpressure: out_ready toggles 1,0,0,1,... -> each word is held stable while out_ready=0, no word is skipped or repeated, 32 transfers total, order 0..31.
- Held done and capture isolation: all_done held high for 100 cycles, and final_res changed to all 16'hFFFF after the capture edge -> exactly one stream, carrying the originally captured values; no second stream.
- Enable gating: all_done pulse with en=0 -> out_valid stays 0 and busy stays 0. A later pulse with en=1 -> normal stream.
- Overrun and back-to-back:
  - second all_done rising edge at word 10 -> overrun=1, the stream completes with the first data;
  - rising edge coincident with the word-31 transfer -> next cycle emits word 0 of the new data, overrun unchanged.
- Reset mid-stream: assert rst while out_idx=17 -> out_valid, out_idx, busy and overrun go to 0 immediately. After release, a new all_done produces a full 32-word stream from index 0.
